// File: rtl/aes128_add_round_key.sv
// rtl/aes128_add_round_key.sv - AddRoundKey stage: byte-wise or bulk state collection XORed with the round key.
// Optional written-byte mask and protocol error flag enabled by defining AES128_ARK_CHECK_EN.
module aes128_add_round_key (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         start_i,
  input  logic [7:0]   byte_data_i,
  input  logic [3:0]   byte_addr_i,
  input  logic         byte_valid_i,
  input  logic         byte_done_i,
  input  logic         bulk_load_i,
  input  logic [127:0] bulk_data_i,
  input  logic [127:0] key_i,
  output logic [127:0] state_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } fsm_e;

  fsm_e         fsm_q, fsm_d;
  logic [127:0] state_q, state_d;
  logic [6:0]   byte_lsb;
  logic         byte_we;
  logic         bulk_we;
  logic         round_clear;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm_q <= ST_IDLE;
    end else begin
      fsm_q <= fsm_d;
    end
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: begin
        if (start_i) begin
          fsm_d = ST_COLLECT;
        end else if (bulk_load_i) begin
          fsm_d = ST_DONE;
        end
      end
      ST_COLLECT: begin
        // A restart takes priority over a simultaneous done.
        if (!start_i && byte_done_i) begin
          fsm_d = ST_DONE;
        end
      end
      ST_DONE: fsm_d = ST_IDLE;
      default: fsm_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o = 1'b0;
    done_o = 1'b0;
    case (fsm_q)
      ST_COLLECT: busy_o = 1'b1;
      ST_DONE: begin
        busy_o = 1'b1;
        done_o = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
        done_o = 1'b0;
      end
    endcase
  end

  always_comb begin
    byte_lsb    = {byte_addr_i, 3'b000};
    round_clear = start_i && ((fsm_q == ST_IDLE) || (fsm_q == ST_COLLECT));
    byte_we     = (fsm_q == ST_COLLECT) && byte_valid_i && !start_i;
    bulk_we     = (fsm_q == ST_IDLE) && bulk_load_i && !start_i;
    state_d     = state_q;
    if (bulk_we) begin
      state_d = bulk_data_i ^ key_i;
    end else if (byte_we) begin
      state_d[byte_lsb +: 8] = byte_data_i ^ key_i[byte_lsb +: 8];
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

`ifdef AES128_ARK_CHECK_EN
  logic [15:0] mask_q, mask_d;
  logic [15:0] mask_wr;
  logic [15:0] addr_onehot;
  logic        err_q, err_d;

  always_comb begin
    addr_onehot = 16'h0001 << byte_addr_i;
    mask_wr     = byte_we ? (mask_q | addr_onehot) : mask_q;
    mask_d      = mask_q;
    err_d       = err_q;
    if (round_clear) begin
      mask_d = '0;
      err_d  = 1'b0;
    end else if (fsm_q == ST_COLLECT) begin
      mask_d = mask_wr;
      if (byte_we && ((mask_q & addr_onehot) != 16'h0000)) begin
        err_d = 1'b1;
      end
      // The completeness test includes a byte written in the same cycle as done.
      if (byte_done_i && (mask_wr != 16'hFFFF)) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mask_q <= '0;
      err_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      err_q  <= err_d;
    end
  end

  assign err_o = err_q;
`else
  logic unused_check;
  assign unused_check = round_clear;
  assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_aes128_add_round_key.sv
// tb/tb_aes128_add_round_key.sv - randomized and directed bench for aes128_add_round_key against a byte-array model.
module tb_aes128_add_round_key;

`ifdef AES128_ARK_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [7:0]   byte_data_i = '0;
  logic [3:0]   byte_addr_i = '0;
  logic         byte_valid_i = 1'b0;
  logic         byte_done_i = 1'b0;
  logic         bulk_load_i = 1'b0;
  logic [127:0] bulk_data_i = '0;
  logic [127:0] key_i = '0;
  logic [127:0] state_o;
  logic         busy_o;
  logic         done_o;
  logic         err_o;

  aes128_add_round_key dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .start_i      (start_i),
    .byte_data_i  (byte_data_i),
    .byte_addr_i  (byte_addr_i),
    .byte_valid_i (byte_valid_i),
    .byte_done_i  (byte_done_i),
    .bulk_load_i  (bulk_load_i),
    .bulk_data_i  (bulk_data_i),
    .key_i        (key_i),
    .state_o      (state_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: phase 0 idle, 1 collecting, 2 done; state kept as 16 bytes.
  logic [7:0] m_st [16];
  bit         m_wr [16];
  int         m_ph;
  bit         m_err;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_st[i] = 8'h00;
      m_wr[i] = 1'b0;
    end
    m_ph  = 0;
    m_err = 1'b0;
  endtask

  function automatic logic [127:0] model_state();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = m_st[i];
    return r;
  endfunction

  function automatic bit all_written();
    for (int i = 0; i < 16; i++) if (!m_wr[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit st, input bit bl, input bit v, input bit dn,
                            input int a, input logic [7:0] d, input logic [127:0] bd);
    case (m_ph)
      0: begin
        if (st) begin
          m_ph  = 1;
          m_err = 1'b0;
          for (int i = 0; i < 16; i++) m_wr[i] = 1'b0;
        end else if (bl) begin
          for (int i = 0; i < 16; i++) m_st[i] = bd[i*8 +: 8] ^ key_i[i*8 +: 8];
          m_ph = 2;
        end
      end
      1: begin
        if (st) begin
          m_err = 1'b0;
          for (int i = 0; i < 16; i++) m_wr[i] = 1'b0;
        end else begin
          if (v) begin
            if (CHK && m_wr[a]) m_err = 1'b1;
            m_wr[a] = 1'b1;
            m_st[a] = d ^ key_i[a*8 +: 8];
          end
          if (dn) begin
            if (CHK && !all_written()) m_err = 1'b1;
            m_ph = 2;
          end
        end
      end
      default: m_ph = 0;
    endcase
  endtask

  task automatic cyc(input bit st, input bit bl, input bit v, input bit dn,
                     input int a, input logic [7:0] d, input logic [127:0] bd);
    start_i      = st;
    bulk_load_i  = bl;
    byte_valid_i = v;
    byte_done_i  = dn;
    byte_addr_i  = a[3:0];
    byte_data_i  = d;
    bulk_data_i  = bd;
    model_edge(st, bl, v, dn, a, d, bd);
    @(posedge clk_i);
    #1;
    check_eq("state", state_o, model_state());
    check_eq("done", done_o, m_ph == 2);
    check_eq("busy", busy_o, m_ph != 0);
    check_eq("err", err_o, m_err);
  endtask

  task automatic idle_cyc();
    cyc(0, 0, 0, 0, 0, 8'h00, '0);
  endtask

  logic [127:0] exp_v;
  logic [127:0] snap;
  int           perm [16];

  initial begin
    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    check_eq("rst_state", state_o, '0);
    check_eq("rst_done", done_o, 1'b0);
    check_eq("rst_busy", busy_o, 1'b0);
    check_eq("rst_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // Sequential bytes under a constant key, done with the last byte.
    key_i = {16{8'h0F}};
    cyc(1, 0, 0, 0, 0, 8'h00, '0);
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, k == 15, k, k[7:0], '0);
    for (int k = 0; k < 16; k++) exp_v[k*8 +: 8] = k[7:0] ^ 8'h0F;
    check_eq("r031_state", state_o, exp_v);
    check_eq("r031_done", done_o, 1'b1);
    check_eq("r031_err", err_o, 1'b0);
    idle_cyc();
    check_eq("r031_done_off", done_o, 1'b0);

    // Bulk load.
    key_i = 128'h000102030405060708090a0b0c0d0e0f;
    cyc(0, 1, 0, 0, 0, 8'h00, 128'h00112233445566778899aabbccddeeff);
    check_eq("r032_state", state_o, 128'h00102030405060708090a0b0c0d0e0f0);
    check_eq("r032_done", done_o, 1'b1);
    idle_cyc();

    // Gapped stream, then stray bytes in DONE and IDLE.
    key_i = {$urandom, $urandom, $urandom, $urandom};
    cyc(1, 0, 0, 0, 0, 8'h00, '0);
    for (int k = 0; k < 16; k++) begin
      cyc(0, 0, 1, k == 15, k, 8'($urandom), '0);
      if (k != 15) repeat (3) idle_cyc();
    end
    snap = model_state();
    for (int k = 0; k < 5; k++) cyc(0, 0, 1, k == 2, $urandom_range(15), 8'($urandom), '0);
    check_eq("r033_hold", state_o, snap);

    // Async reset in the middle of a round.
    cyc(1, 0, 0, 0, 0, 8'h00, '0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0, k, 8'($urandom), '0);
    #2 rst_n_i = 1'b0;
    #1;
    model_reset();
    check_eq("r034_state", state_o, '0);
    check_eq("r034_busy", busy_o, 1'b0);
    check_eq("r034_done", done_o, 1'b0);
    check_eq("r034_err", err_o, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, k == 3, k, 8'($urandom), '0);
    check_eq("r034_ignored", state_o, '0);

    // Duplicate address, then an incomplete round, each followed by a clearing start.
    cyc(1, 0, 0, 0, 0, 8'h00, '0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 0, k, 8'($urandom), '0);
    cyc(0, 0, 1, 0, 5, 8'($urandom), '0);
    check_eq("r035_dup_err", err_o, CHK);
    cyc(1, 0, 0, 0, 0, 8'h00, '0);
    check_eq("r035_clear1", err_o, 1'b0);
    for (int k = 0; k < 15; k++) cyc(0, 0, 1, 0, k, 8'($urandom), '0);
    cyc(0, 0, 0, 1, 0, 8'h00, '0);
    check_eq("r035_short_err", err_o, CHK);
    idle_cyc();
    cyc(1, 0, 0, 0, 0, 8'h00, '0);
    check_eq("r035_clear2", err_o, 1'b0);

    // Restart after 4 bytes (concurrent byte dropped), then a full permuted round.
    for (int k = 0; k < 4; k++) cyc(0, 0, 1, 0, k, 8'($urandom), '0);
    cyc(1, 0, 1, 0, 9, 8'($urandom), '0);
    for (int k = 0; k < 16; k++) perm[k] = k;
    perm.shuffle();
    for (int k = 0; k < 16; k++) cyc(0, 0, 1, k == 15, perm[k], 8'($urandom), '0);
    check_eq("r036_done", done_o, 1'b1);
    check_eq("r036_err", err_o, 1'b0);
    idle_cyc();
    check_eq("r036_once", done_o, 1'b0);

    // Randomized rounds with noise.
    for (int r = 0; r < 40; r++) begin
      key_i = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(3) == 0) begin
        cyc(0, 1, $urandom_range(1), $urandom_range(1), $urandom_range(15), 8'($urandom),
            {$urandom, $urandom, $urandom, $urandom});
      end else begin
        int len;
        len = $urandom_range(30, 8);
        cyc(1, $urandom_range(1), 0, 0, 0, 8'h00, {$urandom, $urandom, $urandom, $urandom});
        for (int c = 0; c < len; c++) begin
          cyc($urandom_range(19) == 0, $urandom_range(1), $urandom_range(2) != 0, c == len - 1,
              $urandom_range(15), 8'($urandom), {$urandom, $urandom, $urandom, $urandom});
        end
      end
      repeat ($urandom_range(3)) begin
        cyc(0, 0, $urandom_range(1), $urandom_range(1), $urandom_range(15), 8'($urandom), '0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/aes128_add_round_key.md
AES128_ADD_ROUND_KEY -- requirements
Module: aes128_add_round_key

Interface
REQ-001 clk_i  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n_i  input  1  asynchronous, active-low reset.
REQ-003 start_i  input  1  begin byte-collection round; clears written mask.
REQ-004 byte_data_i  input  8  MixColumns result byte from upstream stage.
REQ-005 byte_addr_i  input  4  state byte index, col*4+row; byte lives at state[addr*8 +: 8].
REQ-006 byte_valid_i  input  1  byte_data_i/byte_addr_i qualify this cycle.
REQ-007 byte_done_i  input  1  upstream finished; may coincide with final byte_valid_i.
REQ-008 bulk_load_i  input  1  one-shot full-state load (final round, no MixColumns).
REQ-009 bulk_data_i  input  128  state for bulk load.
REQ-010 key_i  input  128  round key; held stable from start_i/bulk_load_i until done_o.
REQ-011 state_o  output  128  registered round output, state XOR key.
REQ-012 busy_o  output  1  high while FSM not IDLE.
REQ-013 done_o  output  1  one-cycle pulse, state_o final.
REQ-014 err_o  output  1  sticky protocol error (see Configuration).

Function
REQ-015 FSM states IDLE, COLLECT, DONE; DONE always returns to IDLE next cycle.
REQ-016 IDLE: start_i -> COLLECT; else bulk_load_i -> DONE; start_i wins if both high.
REQ-017 IDLE bulk_load_i: state_o <= bulk_data_i ^ key_i at same edge (1-cycle latency).
REQ-018 COLLECT: byte_valid_i writes state_o[addr*8 +: 8] <= byte_data_i ^ key_i[addr*8 +: 8]; other bytes held.
REQ-019 Byte write latency: state_o updated at edge ending the valid cycle.
REQ-020 COLLECT: byte_done_i -> DONE; simultaneous byte_valid_i is written at the same edge.
REQ-021 COLLECT: start_i restarts (mask cleared, stays COLLECT); concurrent byte_valid_i ignored.
REQ-022 byte_valid_i, byte_done_i ignored in IDLE and DONE; bulk_load_i ignored outside IDLE.
REQ-023 done_o = 1 exactly in DONE cycle; busy_o = 1 in COLLECT and DONE.
REQ-024 state_o unchanged outside writes; not cleared by start_i.
REQ-025 Repeated writes to one address: last write wins (data path).

Reset
REQ-026 rst_n_i low asynchronously forces: FSM IDLE, state_o 0, done_o 0, busy_o 0, err_o 0, mask 0.
REQ-027 Reset mid-COLLECT abandons round; bytes ignored until next start_i after release.

Configuration
REQ-028 Macro AES128_ARK_CHECK_EN defined: 16-bit written mask kept; set bit addr per accepted byte; cleared by start_i.
REQ-029 With macro: err_o set on write to an already-set mask bit, or byte_done_i while mask (including same-cycle write) not 16'hFFFF; sticky until start_i or reset.
REQ-030 Without macro: no mask register; err_o tied 0; all other behaviour identical.

Verification
REQ-031 key_i=0x0F repeated, start, bytes addr k data k (k=0..15) one per cycle, byte_done_i with k=15 -> state_o byte k = k^0x0F, done_o one pulse next cycle, err_o 0.
REQ-032 IDLE bulk_load_i, bulk_data_i=0x00112233445566778899aabbccddeeff, key_i=0x000102030405060708090a0b0c0d0e0f -> next cycle state_o=0x00102030405060708090a0b0c0d0e0f0, done_o pulse.
REQ-033 Byte stream with 3-cycle gaps, byte_valid_i also asserted in IDLE after done -> IDLE bytes leave state_o unchanged.
REQ-034 rst_n_i low after 7 bytes (async, mid-cycle) -> all outputs 0 immediately, FSM IDLE; later bytes ignored until start_i.
REQ-035 AES128_ARK_CHECK_EN: addr 5 written twice -> err_o 1; separate run byte_done_i after 15 bytes -> err_o 1; next start_i clears.
REQ-036 start_i during COLLECT after 4 bytes, then full 16 bytes -> done_o once, err_o 0, state_o reflects latest writes.
